// File: rtl/if_pkg.sv
// if_pkg: shared constants and helpers for the instruction-fetch path.
//   NOP_INSTR  : word presented to decode when no fetched word is valid
//   TAG_ICACHE : default address tag of the instruction cache region
//   TAG_BIOS   : default address tag of the BIOS ROM region
//   idx_width(): index width for n regions, never below one bit
package if_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [3:0]  TAG_ICACHE = 4'h1;
    localparam logic [3:0]  TAG_BIOS   = 4'h4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/if_region_decoder.sv
// if_region_decoder: compares an address tag against a packed table of region
// tags and reports the lowest-indexed match as a one-hot vector and an index.
// Purely combinational. It is shared with the data-side address decoder.
//   tag_i     : address tag to decode
//   hit_any_o : at least one region matched
//   onehot_o  : one-hot of the first matching region (all zero on a miss)
//   idx_o     : index of the first matching region (0 on a miss)
module if_region_decoder
    import if_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 2,
    parameter int unsigned TAG_W       = 4,
    parameter logic [NUM_REGIONS*TAG_W-1:0] REGION_TAGS = {TAG_BIOS, TAG_ICACHE},
    parameter int unsigned IDX_W       = idx_width(NUM_REGIONS)
) (
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   hit_any_o,
    output logic [NUM_REGIONS-1:0] onehot_o,
    output logic [IDX_W-1:0]       idx_o
);

    always_comb begin
        hit_any_o = 1'b0;
        onehot_o  = '0;
        idx_o     = '0;
        // Stop at the first match so that duplicate tags resolve to the lowest index.
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (!hit_any_o && (tag_i == REGION_TAGS[i*TAG_W +: TAG_W])) begin
                hit_any_o   = 1'b1;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/if_fetch_router.sv
// if_fetch_router: instruction-fetch source router.
// Decodes the fetch PC against the region tag table, drives one-hot read
// enables, registers the selection to line up with the one-cycle memory read
// latency, and muxes the returned word to decode. Misaligned or unmapped
// fetches are faults: a sticky flag and first-fault PC are captured and a
// saturating counter is kept.
//   clk, reset  : clock, synchronous active-high reset
//   pc/pc_valid : fetch address and its qualifier
//   stall       : hold selection and output, suppress requests and faults
//   fault_clr   : clear sticky fault state and counter
//   re          : one-hot read enables (combinational)
//   rd_data     : registered memory outputs, region i at [i*DATA_W +: DATA_W]
//   instr/instr_valid : word to decode and its valid flag
//   fetch_fault/fault_pc/fault_count : fault status
module if_fetch_router
    import if_pkg::*;
#(
    parameter int unsigned NUM_REGIONS = 2,
    parameter int unsigned TAG_W       = 4,
    parameter logic [NUM_REGIONS*TAG_W-1:0] REGION_TAGS = {TAG_BIOS, TAG_ICACHE},
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   pc,
    input  logic                          pc_valid,
    input  logic                          stall,
    input  logic                          fault_clr,
    output logic [NUM_REGIONS-1:0]        re,
    input  logic [NUM_REGIONS*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]             instr,
    output logic                          instr_valid,
    output logic                          fetch_fault,
    output logic [31:0]                   fault_pc,
    output logic [CNT_W-1:0]              fault_count
);

    localparam int unsigned IDX_W = idx_width(NUM_REGIONS);

    logic                   hit_any;
    logic [NUM_REGIONS-1:0] hit_onehot;
    logic [IDX_W-1:0]       hit_idx;

    logic                   fetch_ok;
    logic                   fault_evt;

    logic [IDX_W-1:0] sel_d, sel_q;
    logic             valid_d, valid_q;
    logic             fault_flag_d, fault_flag_q;
    logic [31:0]      fault_pc_d, fault_pc_q;
    logic [CNT_W-1:0] fault_cnt_d, fault_cnt_q;

    if_region_decoder #(
        .NUM_REGIONS (NUM_REGIONS),
        .TAG_W       (TAG_W),
        .REGION_TAGS (REGION_TAGS),
        .IDX_W       (IDX_W)
    ) u_decoder (
        .tag_i     (pc[31:32-TAG_W]),
        .hit_any_o (hit_any),
        .onehot_o  (hit_onehot),
        .idx_o     (hit_idx)
    );

    always_comb begin
        // Reset gates requests so no memory is enabled while state is cleared.
        fetch_ok  = pc_valid && !stall && !reset && (pc[1:0] == 2'b00) && hit_any;
        fault_evt = pc_valid && !stall && !reset && ((pc[1:0] != 2'b00) || !hit_any);
        re        = fetch_ok ? hit_onehot : '0;
    end

    always_comb begin
        sel_d   = stall ? sel_q   : hit_idx;
        valid_d = stall ? valid_q : fetch_ok;

        fault_flag_d = fault_flag_q;
        fault_pc_d   = fault_pc_q;
        fault_cnt_d  = fault_cnt_q;
        if (fault_clr) begin
            fault_flag_d = 1'b0;
            fault_pc_d   = '0;
            fault_cnt_d  = '0;
        end
        // Evaluated after the clear so a coincident fault becomes the first fault.
        if (fault_evt) begin
            if (!fault_flag_d) begin
                fault_flag_d = 1'b1;
                fault_pc_d   = pc;
            end
            if (fault_cnt_d != {CNT_W{1'b1}}) begin
                fault_cnt_d = fault_cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= '0;
            valid_q      <= 1'b0;
            fault_flag_q <= 1'b0;
            fault_pc_q   <= '0;
            fault_cnt_q  <= '0;
        end else begin
            sel_q        <= sel_d;
            valid_q      <= valid_d;
            fault_flag_q <= fault_flag_d;
            fault_pc_q   <= fault_pc_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    always_comb begin
        instr = DATA_W'(NOP_INSTR);
        if (valid_q) begin
            for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                if (sel_q == IDX_W'(i)) begin
                    instr = rd_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign instr_valid = valid_q;
    assign fetch_fault = fault_flag_q;
    assign fault_pc    = fault_pc_q;
    assign fault_count = fault_cnt_q;

endmodule

// File: tb/tb_if_fetch_router.sv
// Bench for if_fetch_router: a default two-region instance and a four-region
// instance with duplicate tags share all control inputs. A per-instance
// reference model predicts re, instr and the fault status each cycle.
module tb_if_fetch_router;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc;
    logic         pc_valid, stall, fault_clr;
    logic [63:0]  rd0;
    logic [127:0] rd1;

    logic [1:0]  re0;
    logic [3:0]  re1;
    logic [31:0] instr0, instr1, fpc0, fpc1;
    logic        iv0, iv1, ff0, ff1;
    logic [7:0]  fc0, fc1;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state, one slot per instance.
    int          nreg[2];
    int          tags[2][4];
    int          m_valid[2], m_sel[2], m_flag[2], m_cnt[2];
    logic [31:0] m_fpc[2];

    always #5 clk = ~clk;

    if_fetch_router dut0 (
        .clk (clk), .reset (reset), .pc (pc), .pc_valid (pc_valid), .stall (stall),
        .fault_clr (fault_clr), .re (re0), .rd_data (rd0), .instr (instr0),
        .instr_valid (iv0), .fetch_fault (ff0), .fault_pc (fpc0), .fault_count (fc0)
    );

    if_fetch_router #(
        .NUM_REGIONS (4),
        .REGION_TAGS (16'h4113)
    ) dut1 (
        .clk (clk), .reset (reset), .pc (pc), .pc_valid (pc_valid), .stall (stall),
        .fault_clr (fault_clr), .re (re1), .rd_data (rd1), .instr (instr1),
        .instr_valid (iv1), .fetch_fault (ff1), .fault_pc (fpc1), .fault_count (fc1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_hit(input int k, input logic [31:0] a);
        for (int i = 0; i < nreg[k]; i++) begin
            if (int'(a[31:28]) == tags[k][i]) return i;
        end
        return -1;
    endfunction

    // One cycle: apply inputs, check outputs, advance the model across the edge.
    task automatic step(input logic [31:0] a, input logic v, input logic s, input logic c,
                        input logic r, input bit hold);
        int          hit;
        bit          ok, flt;
        logic [127:0] exp_instr;
        pc = a; pc_valid = v; stall = s; fault_clr = c; reset = r;
        if (hold) begin
            rd0[31:0] = $urandom;
            rd1[31:0] = $urandom;
        end else begin
            rd0 = {$urandom, $urandom};
            rd1 = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            hit = first_hit(k, a);
            ok  = v && !s && !r && (a[1:0] == 2'b00) && (hit >= 0);
            flt = v && !s && !r && ((a[1:0] != 2'b00) || (hit < 0));
            if (m_valid[k] != 0)
                exp_instr = (k == 0) ? 128'(rd0[m_sel[k]*32 +: 32]) : 128'(rd1[m_sel[k]*32 +: 32]);
            else
                exp_instr = '0;
            if (k == 0) begin
                check("A.re", 128'(re0), ok ? 128'(1) << hit : 128'(0));
                check("A.instr", 128'(instr0), exp_instr);
                check("A.instr_valid", 128'(iv0), 128'(m_valid[k]));
                check("A.fetch_fault", 128'(ff0), 128'(m_flag[k]));
                check("A.fault_pc", 128'(fpc0), 128'(m_fpc[k]));
                check("A.fault_count", 128'(fc0), 128'(m_cnt[k]));
            end else begin
                check("B.re", 128'(re1), ok ? 128'(1) << hit : 128'(0));
                check("B.instr", 128'(instr1), exp_instr);
                check("B.instr_valid", 128'(iv1), 128'(m_valid[k]));
                check("B.fetch_fault", 128'(ff1), 128'(m_flag[k]));
                check("B.fault_pc", 128'(fpc1), 128'(m_fpc[k]));
                check("B.fault_count", 128'(fc1), 128'(m_cnt[k]));
            end
            if (r) begin
                m_valid[k] = 0; m_sel[k] = 0; m_flag[k] = 0; m_fpc[k] = '0; m_cnt[k] = 0;
            end else begin
                if (!s) begin
                    m_valid[k] = ok ? 1 : 0;
                    m_sel[k]   = (hit < 0) ? 0 : hit;
                end
                if (c) begin
                    m_flag[k] = 0; m_fpc[k] = '0; m_cnt[k] = 0;
                end
                if (flt) begin
                    if (m_flag[k] == 0) begin
                        m_flag[k] = 1;
                        m_fpc[k]  = a;
                    end
                    if (m_cnt[k] < 255) m_cnt[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  nib;
        nreg[0] = 2; tags[0] = '{1, 4, 0, 0};
        nreg[1] = 4; tags[1] = '{3, 1, 1, 4};
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_sel[k] = 0; m_flag[k] = 0; m_fpc[k] = '0; m_cnt[k] = 0;
        end
        reset = 1'b1; pc = '0; pc_valid = 1'b0; stall = 1'b0; fault_clr = 1'b0;
        rd0 = '0; rd1 = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state with reset still asserted (re must stay low).
        step(32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Basic icache fetch, then alternating regions without bubbles.
        step(32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step((i % 2 == 0) ? 32'h4000_0004 : 32'h1000_0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // BIOS fetch then a three-cycle stall while only region0 data moves.
        step(32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(32'h2000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();

        // Unmapped then misaligned fetch.
        step(32'h2000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h1000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Clear coinciding with a new fault, then counter saturation.
        step(32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 300; i++)
            step(32'hF000_0000 | (32'(i) << 2), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Reset in the middle of a stall with fault state held.
        step(32'h1000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(32'h1000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(32'h1000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: nib = 4'h1;
                1: nib = 4'h4;
                2: nib = 4'h3;
                3: nib = 4'h2;
                default: nib = 4'($urandom);
            endcase
            a = {nib, 28'($urandom)};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            step(a, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 0));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_router.md
# if_fetch_router

Parametrised instruction-fetch source router for the MIPS150 IF stage. Decodes the fetch PC's top address bits against a configurable set of memory regions (instruction cache, BIOS, further ROM/RAM regions) and drives one-hot read enables. Registers the selection to match the one-cycle synchronous memory read latency, then muxes the returned instruction word to the decode stage. Adds stall-hold, misaligned/unmapped-fetch fault detection with sticky capture, and a saturating fault counter.

## Interface
- NUM_REGIONS, 2, number of fetchable memory regions (1..8)
- TAG_W, 4, PC bits [31:32-TAG_W] compared per region
- REGION_TAGS, 8'h41, packed tags, region i at [i*TAG_W +: TAG_W]; default region0 = 4'h1 (icache), region1 = 4'h4 (BIOS)
- DATA_W, 32, instruction width
- CNT_W, 8, fault counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc  in  32  fetch address, valid this cycle
- pc_valid  in  1  fetch request qualifier
- stall  in  1  pipeline stall; hold everything
- fault_clr  in  1  clears sticky fault and counter
- re  out  NUM_REGIONS  one-hot read enable to region memories (combinational)
- rd_data  in  NUM_REGIONS*DATA_W  registered memory outputs, region i at [i*DATA_W +: DATA_W]
- instr  out  DATA_W  instruction to decode
- instr_valid  out  1  instr is a real fetched word
- fetch_fault  out  1  sticky fault flag
- fault_pc  out  32  PC of first fault since clear
- fault_count  out  CNT_W  saturating fault count

## Operation
- Decode: hit[i] = (pc[31:32-TAG_W] == tag i). Lowest index wins on duplicate tags. re = onehot(first hit) when pc_valid && !stall && pc[1:0]==0 && any hit; else re = 0.
- Fault event: pc_valid && !stall && (pc[1:0]!=0 || no hit). re = 0 on a fault.
- Select register sel_q (index) and valid_q load every non-stall cycle: sel_q <= winning index (0 if none), valid_q <= (re != 0).
- Output: instr = valid_q ? rd_data[sel_q] : NOP (32'h0000_0000); instr_valid = valid_q.
- Stall: re = 0, sel_q/valid_q held, so instr holds (memories hold output while enable low). No fault events during stall.
- Fault capture: on a fault event with fetch_fault==0, fault_pc <= pc and fetch_fault <= 1. Later faults do not overwrite fault_pc. fault_count increments per fault event, saturating at 2^CNT_W-1.
- fault_clr: clears fetch_fault, fault_pc, fault_count. If a fault event occurs in the same cycle, the new fault wins: fetch_fault=1, fault_pc=pc, fault_count=1.
- Reset values: sel_q=0, valid_q=0, instr=NOP, instr_valid=0, fetch_fault=0, fault_pc=0, fault_count=0. re is 0 during reset. Reset mid-stall or mid-fault discards all state.

## Timing
- pc -> re: combinational, same cycle.
- pc -> instr/instr_valid: 1 cycle (cycle N request, cycle N+1 data).
- Stall at N+1 extends instr/instr_valid from N+1 for every stalled cycle. The next non-stalled cycle loads the new selection.
- Fault flags/counter update at the edge ending the fault cycle, visible at N+1, same as the instr_valid=0 bubble.
- Back-to-back fetches to different regions: full throughput, one instruction per cycle, no bubble.

## Structure
- Shared package if_pkg: NOP_INSTR constant, IDX_W = $clog2(NUM_REGIONS) (min 1), default tag constants TAG_ICACHE=4'h1, TAG_BIOS=4'h4.
- Sub-module if_region_decoder: combinational tag compare plus priority one-hot and index; reusable by the data-side address decoder.
- Top holds the sel/valid registers, output mux, and fault logic.

## Test plan
- Reset, then pc=32'h1000_0000 valid: re=2'b01 same cycle; next cycle instr=rd_data[31:0], instr_valid=1.
- Alternate pc=32'h4000_0004 / 32'h1000_0008 each cycle: re toggles 10/01; instr follows with 1-cycle lag, no bubbles.
- pc=32'h4000_0000, then stall=1 for 3 cycles while rd_data changes only on the region0 slice: re=0, instr holds the BIOS word, no counter change.
- pc=32'h2000_0000, then pc=32'h1000_0002: re=0 both cycles, instr_valid=0, fetch_fault=1, fault_pc=32'h2000_0000, fault_count=2.
- fault_clr together with fault pc=32'h8000_0000: fault_pc=32'h8000_0000, fault_count=1. Then 300 faults with CNT_W=8: count saturates at 255.
- NUM_REGIONS=4, REGION_TAGS=16'h4_1_1_3: pc=32'h1xxx_xxx0 gives re=4'b0010 (lowest duplicate). Assert reset mid-sequence: all outputs return to reset values next cycle.
